mc_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32I datapath. It breaks each instruction into fetch, decode, execute, memory and write-back phases, and drives the instruction- and data-memory request/ready handshakes. It turns the single-cycle decoder's level outputs (register write, memory write) into per-phase one-cycle strobes. It sits between the decoder and the PC, IR, MDR and register-file write enables.

---
 rtl/mc_seq_pkg.sv | 45 ++++
 rtl/mc_wait_timer.sv | 48 ++++
 rtl/mc_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_mc_seq_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mc_seq_pkg.sv
// ============================================================================
// Module   : mc_seq_pkg
// Brief    : Shared types and opcode constants for the multi-cycle sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd7
  } state_e;

  localparam logic [6:0] OP_RTYPE   = 7'b0110011;
  localparam logic [6:0] OP_ITYPE_R = 7'b0010011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_LUI     = 7'b0110111;

  // Wide enough for the largest legal MAX_WAIT (255).
  localparam int WAIT_CNT_W = 8;

  function automatic state_e decode_next(input logic [6:0] op);
    state_e nxt;
    case (op)
      OP_LOAD, OP_STORE:                     nxt = ST_MEM;
      OP_RTYPE, OP_ITYPE_R, OP_BRANCH,
      OP_JAL, OP_JALR, OP_AUIPC, OP_LUI:     nxt = ST_EXEC;
      default:                               nxt = ST_FAULT;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_wait_timer.sv
// ============================================================================
// Module   : mc_wait_timer
// Brief    : Memory wait counter; expired_o flags the count reaching MAX_WAIT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_wait_timer
  import mc_seq_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [WAIT_CNT_W-1:0] c_MAX_WAIT = WAIT_CNT_W'(MAX_WAIT);
  localparam logic [WAIT_CNT_W-1:0] c_ONE      = WAIT_CNT_W'(1);

  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [WAIT_CNT_W-1:0] cnt_d;

  // Saturates at the limit so a stuck enable can never wrap past it.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != c_MAX_WAIT)) begin
      cnt_d = cnt_q + c_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == c_MAX_WAIT);

endmodule

`default_nettype wire

// File: rtl/mc_seq_ctrl.sv
// ============================================================================
// Module   : mc_seq_ctrl
// Brief    : RV32I multi-cycle phase sequencer and memory handshake control.
//            Define MC_SEQ_CTRL_INSTRET_EN to build the retired-instr counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_seq_ctrl
  import mc_seq_pkg::*;
#(
  parameter int MAX_WAIT  = 15,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           Op,
  input  logic                 RegWrite_d,
  input  logic                 MemWrite_d,
  output logic                 imem_req,
  input  logic                 imem_ready,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ready,
  output logic                 IRWrite,
  output logic                 MDRWrite,
  output logic                 RegWrite,
  output logic                 PCWrite,
  output logic                 fault,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  state_e state_q;
  state_e state_d;
  logic   w_timer_clr;
  logic   w_timer_en;
  logic   w_expired;

  // Any phase change clears the timer, covering entry to FETCH and MEM.
  assign w_timer_clr = (state_d != state_q);
  assign w_timer_en  = ((state_q == ST_FETCH) && !imem_ready) ||
                       ((state_q == ST_MEM)   && !dmem_ready);

  mc_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (w_timer_clr),
    .en_i      (w_timer_en),
    .expired_o (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ready)     state_d = ST_DECODE;
        else if (w_expired) state_d = ST_FAULT;
      end
      ST_DECODE: state_d = decode_next(Op);
      ST_EXEC:   state_d = ST_FETCH;
      ST_MEM: begin
        if (dmem_ready)     state_d = MemWrite_d ? ST_FETCH : ST_WB;
        else if (w_expired) state_d = ST_FAULT;
      end
      ST_WB:     state_d = ST_FETCH;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_FAULT;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    IRWrite  = 1'b0;
    MDRWrite = 1'b0;
    RegWrite = 1'b0;
    PCWrite  = 1'b0;
    fault    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        IRWrite  = imem_ready;
      end
      ST_EXEC: begin
        RegWrite = RegWrite_d;
        PCWrite  = 1'b1;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = MemWrite_d;
        PCWrite  = dmem_ready && MemWrite_d;
        MDRWrite = dmem_ready && !MemWrite_d;
      end
      ST_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
      end
      ST_FAULT: fault = 1'b1;
      default:  fault = 1'b0;
    endcase
  end

  assign state = state_q;

`ifdef MC_SEQ_CTRL_INSTRET_EN
  localparam logic [INSTRET_W-1:0] c_INSTRET_ONE = INSTRET_W'(1);

  logic [INSTRET_W-1:0] instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else if (PCWrite) begin
      instret_q <= instret_q + c_INSTRET_ONE;
    end
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_seq_ctrl.sv
// ============================================================================
// Module   : tb_mc_seq_ctrl
// Brief    : Self-checking bench for mc_seq_ctrl (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_seq_ctrl;

  localparam logic [6:0] c_R   = 7'b0110011;
  localparam logic [6:0] c_BR  = 7'b1100011;
  localparam logic [6:0] c_LD  = 7'b0000011;
  localparam logic [6:0] c_ST  = 7'b0100011;
  localparam logic [6:0] c_LUI = 7'b0110111;
  localparam logic [6:0] c_ILL = 7'b0000000;

  // o = {imem_req, dmem_req, dmem_we, IRWrite, MDRWrite, RegWrite, PCWrite, fault}
  typedef struct packed {
    logic       r;
    logic [6:0] op;
    logic       rwd;
    logic       mwd;
    logic       ir;
    logic       dr;
    logic [2:0] st;
    logic [7:0] o;
  } vec_t;

  typedef struct packed {
    logic [10:0] outs;
    logic [31:0] instret;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  Op;
  logic        RegWrite_d, MemWrite_d;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
  logic        IRWrite, MDRWrite, RegWrite, PCWrite, fault;
  logic [2:0]  state;
  logic [31:0] instret;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          step_no = 0;
  logic [31:0] model_instret = 0;
  exp_t        sb_q[$];
  vec_t        vt[$];

  always #5 clk = ~clk;

  mc_seq_ctrl #(
    .MAX_WAIT  (4),
    .INSTRET_W (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Op         (Op),
    .RegWrite_d (RegWrite_d),
    .MemWrite_d (MemWrite_d),
    .imem_req   (imem_req),
    .imem_ready (imem_ready),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ready (dmem_ready),
    .IRWrite    (IRWrite),
    .MDRWrite   (MDRWrite),
    .RegWrite   (RegWrite),
    .PCWrite    (PCWrite),
    .fault      (fault),
    .state      (state),
    .instret    (instret)
  );

  function automatic vec_t mkv(input logic r, input logic [6:0] op, input logic rwd,
                               input logic mwd, input logic ir, input logic dr,
                               input logic [2:0] st, input logic [7:0] o);
    vec_t v;
    v.r = r; v.op = op; v.rwd = rwd; v.mwd = mwd;
    v.ir = ir; v.dr = dr; v.st = st; v.o = o;
    return v;
  endfunction

  // Drive one cycle, queue its expectation, compare mid-cycle, then advance.
  task automatic step(input vec_t v);
    exp_t e;
    exp_t got;
    rst = v.r; Op = v.op; RegWrite_d = v.rwd; MemWrite_d = v.mwd;
    imem_ready = v.ir; dmem_ready = v.dr;
`ifdef MC_SEQ_CTRL_INSTRET_EN
    sb_q.push_back({v.st, v.o, model_instret});
`else
    sb_q.push_back({v.st, v.o, 32'd0});
`endif
    @(negedge clk);
    e = sb_q.pop_front();
    got.outs = {state, imem_req, dmem_req, dmem_we, IRWrite, MDRWrite,
                RegWrite, PCWrite, fault};
    got.instret = instret;
    n_cmp++;
    if (got.outs !== e.outs) begin
      n_bad++;
      $display("FAIL step%0d.outs {st,ireq,dreq,we,ir,mdr,rw,pc,flt} got=%b exp=%b",
               step_no, got.outs, e.outs);
    end
    n_cmp++;
    if (got.instret !== e.instret) begin
      n_bad++;
      $display("FAIL step%0d.instret got=%0d exp=%0d", step_no, got.instret, e.instret);
    end
    @(posedge clk);
    #1;
    if (v.r) model_instret = 0;
    else if (v.o[1]) model_instret = model_instret + 1;
    step_no++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; Op = c_R; RegWrite_d = 1'b0; MemWrite_d = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then ALU add
    vt.push_back(mkv(0, c_R,   1, 0, 0, 0, 3'd0, 8'b1000_0000));
    vt.push_back(mkv(0, c_R,   1, 0, 1, 0, 3'd0, 8'b1001_0000));
    vt.push_back(mkv(0, c_R,   1, 0, 1, 0, 3'd1, 8'b0000_0000));
    vt.push_back(mkv(0, c_R,   1, 0, 1, 0, 3'd2, 8'b0000_0110));
    // Branch: no register write
    vt.push_back(mkv(0, c_BR,  0, 0, 1, 0, 3'd0, 8'b1001_0000));
    vt.push_back(mkv(0, c_BR,  0, 0, 1, 0, 3'd1, 8'b0000_0000));
    vt.push_back(mkv(0, c_BR,  0, 0, 1, 0, 3'd2, 8'b0000_0010));
    // Load with 3 wait cycles; stray dmem_ready in DECODE is ignored
    vt.push_back(mkv(0, c_LD,  0, 0, 1, 0, 3'd0, 8'b1001_0000));
    vt.push_back(mkv(0, c_LD,  0, 1, 0, 1, 3'd1, 8'b0000_0000));
    for (int i = 0; i < 3; i++)
      vt.push_back(mkv(0, c_LD, 0, 0, 0, 0, 3'd3, 8'b0100_0000));
    vt.push_back(mkv(0, c_LD,  0, 0, 0, 1, 3'd3, 8'b0100_1000));
    vt.push_back(mkv(0, c_LD,  0, 0, 0, 0, 3'd4, 8'b0000_0110));
    // Store after one fetch wait; RegWrite_d is ignored in MEM
    vt.push_back(mkv(0, c_ST,  0, 1, 0, 0, 3'd0, 8'b1000_0000));
    vt.push_back(mkv(0, c_ST,  0, 1, 1, 0, 3'd0, 8'b1001_0000));
    vt.push_back(mkv(0, c_ST,  0, 1, 0, 0, 3'd1, 8'b0000_0000));
    vt.push_back(mkv(0, c_ST,  1, 1, 0, 0, 3'd3, 8'b0110_0000));
    vt.push_back(mkv(0, c_ST,  1, 1, 0, 1, 3'd3, 8'b0110_0010));
    // LUI
    vt.push_back(mkv(0, c_LUI, 1, 0, 1, 0, 3'd0, 8'b1001_0000));
    vt.push_back(mkv(0, c_LUI, 1, 0, 0, 0, 3'd1, 8'b0000_0000));
    vt.push_back(mkv(0, c_LUI, 1, 0, 0, 0, 3'd2, 8'b0000_0110));
    // Load whose ready arrives exactly when the wait count hits MAX_WAIT
    vt.push_back(mkv(0, c_LD,  0, 0, 1, 0, 3'd0, 8'b1001_0000));
    vt.push_back(mkv(0, c_LD,  0, 0, 0, 0, 3'd1, 8'b0000_0000));
    for (int i = 0; i < 4; i++)
      vt.push_back(mkv(0, c_LD, 0, 0, 0, 0, 3'd3, 8'b0100_0000));
    vt.push_back(mkv(0, c_LD,  0, 0, 0, 1, 3'd3, 8'b0100_1000));
    vt.push_back(mkv(0, c_LD,  0, 0, 0, 0, 3'd4, 8'b0000_0110));

    for (int i = 0; i < vt.size(); i++) step(vt[i]);

    // Fetch ready arriving in the 5th request cycle wins; then illegal opcode
    for (int i = 0; i < 4; i++) step(mkv(0, c_ILL, 0, 0, 0, 0, 3'd0, 8'b1000_0000));
    step(mkv(0, c_ILL, 0, 0, 1, 0, 3'd0, 8'b1001_0000));
    step(mkv(0, c_ILL, 0, 0, 0, 0, 3'd1, 8'b0000_0000));
    step(mkv(0, c_R,   1, 1, 1, 1, 3'd7, 8'b0000_0001));
    step(mkv(0, c_R,   1, 1, 1, 1, 3'd7, 8'b0000_0001));
    step(mkv(1, c_R,   0, 0, 0, 0, 3'd7, 8'b0000_0001));

    // Fetch timeout: 5 request cycles without ready, then FAULT
    for (int i = 0; i < 5; i++) step(mkv(0, c_R, 0, 0, 0, 0, 3'd0, 8'b1000_0000));
    step(mkv(0, c_R, 0, 0, 1, 0, 3'd7, 8'b0000_0001));
    step(mkv(1, c_R, 0, 0, 0, 0, 3'd7, 8'b0000_0001));

    // Reset during a MEM wait; a late dmem_ready must be ignored
    step(mkv(0, c_LD, 0, 0, 1, 0, 3'd0, 8'b1001_0000));
    step(mkv(0, c_LD, 0, 0, 0, 0, 3'd1, 8'b0000_0000));
    step(mkv(0, c_LD, 0, 0, 0, 0, 3'd3, 8'b0100_0000));
    step(mkv(1, c_LD, 0, 0, 0, 0, 3'd3, 8'b0100_0000));
    step(mkv(0, c_LD, 0, 0, 0, 1, 3'd0, 8'b1000_0000));
    step(mkv(0, c_LD, 0, 0, 0, 1, 3'd0, 8'b1000_0000));
    step(mkv(0, c_R,  0, 0, 1, 0, 3'd0, 8'b1001_0000));
    step(mkv(0, c_R,  0, 0, 0, 0, 3'd1, 8'b0000_0000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
